// File: rtl/sine_phase_sequencer_pkg.sv
// Shared constants for the sine path: the fixed-point format of the angle,
// the pi/2 constant used by both the sequencer and the CORDIC stage, and the
// sequencer state encoding.
//   FIX_SHIFT : number of fraction bits in angles and results
//   PI2       : pi/2 in that fixed-point format
//   FULL_TURN : 2*pi (phase wraps here)
//   STEP_MAX  : pi, the largest allowed phase step
package sine_phase_sequencer_pkg;

    localparam int FIX_SHIFT = 14;
    localparam int PI2       = 25736;      // round(pi/2 * 2^14)
    localparam int FULL_TURN = 4 * PI2;
    localparam int STEP_MAX  = 2 * PI2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_SETTLE,
        S_WAIT,
        S_OUT,
        S_END
    } seq_state_t;

endpackage

// File: rtl/sine_phase_sequencer_if.sv
// Bus bundle between the phase sequencer, the CORDIC stage and the
// downstream sample consumer.
//   cordic_update  : one-cycle request pulse to the CORDIC
//   cordic_angle   : angle presented to the CORDIC (held for the whole computation)
//   cordic_ready   : CORDIC result-valid level, high until the next request
//   cordic_result  : signed CORDIC output
//   sample         : registered output sample
//   sample_valid   : sample is available
//   sample_ready   : downstream accepts the sample
// master = sequencer side, slave = CORDIC / consumer side.
interface sine_phase_sequencer_if #(
    parameter int ANGLE_W  = 18,
    parameter int SAMPLE_W = 16
);
    logic                cordic_update;
    logic [ANGLE_W-1:0]  cordic_angle;
    logic                cordic_ready;
    logic [SAMPLE_W-1:0] cordic_result;
    logic [SAMPLE_W-1:0] sample;
    logic                sample_valid;
    logic                sample_ready;

    modport master (
        output cordic_update, cordic_angle, sample, sample_valid,
        input  cordic_ready, cordic_result, sample_ready
    );

    modport slave (
        input  cordic_update, cordic_angle, sample, sample_valid,
        output cordic_ready, cordic_result, sample_ready
    );
endinterface

// File: rtl/sine_phase_sequencer_phase_wrap_add.sv
// Combinational phase advance: next = (phase + step) mod 2*pi, for
// phase in [0, 2*pi) and step <= pi, so a single conditional subtract suffices.
//   phase      : current phase
//   step       : phase increment
//   next_phase : wrapped sum, always in [0, FULL_TURN)
module phase_wrap_add
    import sine_phase_sequencer_pkg::*;
#(
    parameter int ANGLE_W = 18
) (
    input  logic [ANGLE_W-1:0] phase,
    input  logic [ANGLE_W-1:0] step,
    output logic [ANGLE_W-1:0] next_phase
);
    localparam logic [ANGLE_W:0] FULL = (ANGLE_W+1)'(FULL_TURN);

    logic [ANGLE_W:0] sum;

    always_comb begin
        sum = {1'b0, phase} + {1'b0, step};
        if (sum >= FULL) begin
            next_phase = ANGLE_W'(sum - FULL);
        end else begin
            next_phase = ANGLE_W'(sum);
        end
    end
endmodule

// File: rtl/sine_phase_sequencer.sv
// Phase accumulator and handshake controller in front of the CORDIC sine
// stage. Produces phases 0, step, 2*step, ... mod 2*pi, issues one CORDIC
// request per phase, captures the result and offers it on a valid/ready
// sample stream. Runs n_samples samples, or until stop when n_samples is 0.
//   clk, reset : clock, synchronous active-high reset
//   start      : one-cycle pulse, latches step/n_samples and begins a run
//   stop       : end the run after the current sample is accepted
//   step       : phase increment (saturated to pi)
//   n_samples  : run length, 0 = free-running
//   busy       : run in progress
//   done       : one-cycle pulse when a run ends
//   bus        : CORDIC request/result and sample stream (master side)
module sine_phase_sequencer
    import sine_phase_sequencer_pkg::*;
#(
    parameter int ANGLE_W  = 18,
    parameter int SAMPLE_W = 16,
    parameter int COUNT_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic [ANGLE_W-1:0]  step,
    input  logic [COUNT_W-1:0]  n_samples,
    output logic                busy,
    output logic                done,
    sine_phase_sequencer_if.master bus
);
    localparam logic [ANGLE_W-1:0] STEP_LIMIT = ANGLE_W'(STEP_MAX);

    seq_state_t          state_q, state_d;
    logic [ANGLE_W-1:0]  phase_q;
    logic [ANGLE_W-1:0]  next_phase;
    logic [ANGLE_W-1:0]  step_q;
    logic [ANGLE_W-1:0]  step_sat;
    logic [COUNT_W-1:0]  n_q;
    logic [COUNT_W-1:0]  count_q;
    logic [COUNT_W-1:0]  count_inc;
    logic [SAMPLE_W-1:0] sample_q;
    logic                stop_seen_q;
    logic                handshake;
    logic                end_run;

    phase_wrap_add #(.ANGLE_W(ANGLE_W)) u_wrap (
        .phase      (phase_q),
        .step       (step_q),
        .next_phase (next_phase)
    );

    assign step_sat  = (step > STEP_LIMIT) ? STEP_LIMIT : step;
    assign handshake = (state_q == S_OUT) && bus.sample_ready;
    assign count_inc = count_q + COUNT_W'(1);
    // stop in the handshake cycle itself also counts, so stop and the final
    // count landing together still give a single END visit.
    assign end_run   = ((n_q != '0) && (count_inc == n_q)) || stop_seen_q || stop;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_ISSUE;
            S_ISSUE:  state_d = S_SETTLE;
            // One dead cycle so a ready level left over from the previous
            // result is not mistaken for the new one.
            S_SETTLE: state_d = S_WAIT;
            S_WAIT:   if (bus.cordic_ready) state_d = S_OUT;
            S_OUT:    if (handshake) state_d = end_run ? S_END : S_ISSUE;
            S_END:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.cordic_update = (state_q == S_ISSUE);
        bus.cordic_angle  = phase_q;
        bus.sample        = sample_q;
        bus.sample_valid  = (state_q == S_OUT);
        busy              = (state_q != S_IDLE);
        done              = (state_q == S_END);
    end

    // Run registers: phase only moves on the handshake, which keeps the
    // CORDIC input stable from ISSUE through WAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q     <= '0;
            step_q      <= '0;
            n_q         <= '0;
            count_q     <= '0;
            sample_q    <= '0;
            stop_seen_q <= 1'b0;
        end else begin
            if (state_q == S_IDLE) begin
                if (start) begin
                    step_q      <= step_sat;
                    n_q         <= n_samples;
                    phase_q     <= '0;
                    count_q     <= '0;
                    stop_seen_q <= 1'b0;
                end
            end else if (stop) begin
                stop_seen_q <= 1'b1;
            end

            if ((state_q == S_WAIT) && bus.cordic_ready) begin
                sample_q <= bus.cordic_result;
            end

            if (handshake) begin
                phase_q <= next_phase;
                count_q <= count_inc;
            end
        end
    end
endmodule
